// File: rtl/led_pkg.sv
// Shared widths, lane offsets and swap-state encoding for the LED framebuffer.
package led_pkg;

  // Bit offsets of each colour line inside a chain's 6-bit led_data lane.
  localparam int unsigned LANE_R0 = 0;
  localparam int unsigned LANE_G0 = 1;
  localparam int unsigned LANE_B0 = 2;
  localparam int unsigned LANE_R1 = 3;
  localparam int unsigned LANE_G1 = 4;
  localparam int unsigned LANE_B1 = 5;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned line_of(input int unsigned width, input int unsigned chain_len);
    return width * chain_len;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module fb_bank_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/led_framebuffer.sv
// Double-buffered pixel store: host writes the back buffer, the blitter reads the
// front buffer bit-plane by bit-plane; buffers swap only on a vsync rising edge.
module led_framebuffer
  import led_pkg::*;
#(
  parameter int unsigned C_LED_CHAINS       = 4,
  parameter int unsigned C_LED_CHAIN_LENGTH = 4,
  parameter int unsigned C_LED_NBANKS       = 16,
  parameter int unsigned C_LED_WIDTH        = 32,
  parameter int unsigned C_LED_CLKDIV       = 8,
  parameter int unsigned C_BPC              = 12,
  localparam int unsigned LINE = line_of(C_LED_WIDTH, C_LED_CHAIN_LENGTH),
  localparam int unsigned XW   = width_of(LINE),
  localparam int unsigned YW   = width_of(C_LED_NBANKS),
  localparam int unsigned BW   = width_of(C_BPC),
  localparam int unsigned CW   = width_of(C_LED_CHAINS)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      disp_en,
  input  logic [XW-1:0]             ctl_cur_x,
  input  logic [YW-1:0]             ctl_cur_y,
  input  logic [BW-1:0]             ctl_cur_bit,
  input  logic                      ctl_vsync,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CW-1:0]             wr_chain,
  input  logic                      wr_half,
  input  logic [YW-1:0]             wr_y,
  input  logic [XW-1:0]             wr_x,
  input  logic [3*C_BPC-1:0]        wr_rgb,
  input  logic                      swap_req,
  output logic                      swap_pending,
  output logic                      swap_done,
  output logic                      front_sel,
  output logic [6*C_LED_CHAINS-1:0] led_data
);

  localparam int unsigned PW    = 3 * C_BPC;
  localparam int unsigned AW    = 1 + YW + XW;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NRAM  = 2 * C_LED_CHAINS;

  if (C_LED_CLKDIV < 6) begin : g_clkdiv_chk
    $error("C_LED_CLKDIV must be at least 6");
  end

  swap_state_e state_q, state_d;
  logic        front_q, front_d;
  logic        done_q, done_d;
  logic        vs_prev_q;
  logic        vs_edge;

  assign vs_edge = ctl_vsync & ~vs_prev_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= SWAP_IDLE;
      front_q   <= 1'b0;
      done_q    <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      done_q    <= done_d;
      vs_prev_q <= ctl_vsync;
    end
  end

  // A request landing on a vsync edge only arms the swap; it fires on the next edge.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    done_d  = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (vs_edge) begin
          state_d = SWAP_IDLE;
          front_d = ~front_q;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign swap_pending = (state_q == SWAP_PENDING);
  assign wr_ready     = ~swap_pending;
  assign swap_done    = done_q;
  assign front_sel    = front_q;

  logic          wr_fire;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;

  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (32'(wr_x) < LINE) && (32'(wr_y) < C_LED_NBANKS) &&
                       (32'(wr_chain) < C_LED_CHAINS);
  assign wr_addr     = {~front_q, wr_y, wr_x};

  logic [AW-1:0]                rd_addr_q;
  logic [BW-1:0]                bit0_q, bit1_q;
  logic [NRAM-1:0][PW-1:0]      rd_data;
  logic [NRAM-1:0]              ram_we;
  logic [6*C_LED_CHAINS-1:0]    led_q, led_d;

  for (genvar r = 0; r < NRAM; r++) begin : g_ram
    assign ram_we[r] = wr_fire && wr_in_range &&
                       (wr_chain == CW'(r / 2)) && (wr_half == 1'(r % 2));

    fb_bank_ram #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
    ) u_ram (
      .clk_i   (sys_clk),
      .we_i    (ram_we[r]),
      .waddr_i (wr_addr),
      .wdata_i (wr_rgb),
      .raddr_i (rd_addr_q),
      .rdata_o (rd_data[r])
    );
  end

  // Buffer select is latched with the address so a swap never splits a pixel.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_addr_q <= '0;
      bit0_q    <= '0;
      bit1_q    <= '0;
      led_q     <= '0;
    end else begin
      rd_addr_q <= {front_q, ctl_cur_y, ctl_cur_x};
      bit0_q    <= ctl_cur_bit;
      bit1_q    <= bit0_q;
      led_q     <= led_d;
    end
  end

  always_comb begin
    logic [PW-1:0] lo;
    logic [PW-1:0] hi;
    led_d = '0;
    lo    = '0;
    hi    = '0;
    if (disp_en && (32'(bit1_q) < C_BPC)) begin
      for (int unsigned c = 0; c < C_LED_CHAINS; c++) begin
        lo = rd_data[2*c]   >> bit1_q;
        hi = rd_data[2*c+1] >> bit1_q;
        led_d[6*c+LANE_R0] = lo[2*C_BPC];
        led_d[6*c+LANE_G0] = lo[C_BPC];
        led_d[6*c+LANE_B0] = lo[0];
        led_d[6*c+LANE_R1] = hi[2*C_BPC];
        led_d[6*c+LANE_G1] = hi[C_BPC];
        led_d[6*c+LANE_B1] = hi[0];
      end
    end
  end

  assign led_data = led_q;

endmodule

// File: tb/tb_led_framebuffer.sv
// Directed self-checking bench for led_framebuffer with default parameters.
module tb_led_framebuffer;

  logic        sys_clk;
  logic        sys_rst;
  logic        disp_en;
  logic [6:0]  ctl_cur_x;
  logic [3:0]  ctl_cur_y;
  logic [3:0]  ctl_cur_bit;
  logic        ctl_vsync;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_chain;
  logic        wr_half;
  logic [3:0]  wr_y;
  logic [6:0]  wr_x;
  logic [35:0] wr_rgb;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_done;
  logic        front_sel;
  logic [23:0] led_data;

  int vectors    = 0;
  int miscompares = 0;

  led_framebuffer #(
    .C_LED_CHAINS       (4),
    .C_LED_CHAIN_LENGTH (4),
    .C_LED_NBANKS       (16),
    .C_LED_WIDTH        (32),
    .C_LED_CLKDIV       (8),
    .C_BPC              (12)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .disp_en      (disp_en),
    .ctl_cur_x    (ctl_cur_x),
    .ctl_cur_y    (ctl_cur_y),
    .ctl_cur_bit  (ctl_cur_bit),
    .ctl_vsync    (ctl_vsync),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_chain     (wr_chain),
    .wr_half      (wr_half),
    .wr_y         (wr_y),
    .wr_x         (wr_x),
    .wr_rgb       (wr_rgb),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel),
    .led_data     (led_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; disp_en = 1'b0; ctl_cur_x = '0; ctl_cur_y = '0; ctl_cur_bit = '0;
    ctl_vsync = 1'b0; wr_valid = 1'b0; wr_chain = '0; wr_half = 1'b0; wr_y = '0;
    wr_x = '0; wr_rgb = '0; swap_req = 1'b0;
    #2 sys_rst = 1'b0;
    tick(3);
    vectors++; if (led_data !== 24'h0) begin miscompares++; $display("FAIL reset_led_in_reset: got %h expected 000000", led_data); end
    sys_rst = 1'b1;
    tick(1);
    vectors++; if (led_data !== 24'h0) begin miscompares++; $display("FAIL reset_led: got %h expected 000000", led_data); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL reset_front_sel: got %b expected 0", front_sel); end
    vectors++; if (swap_pending !== 1'b0) begin miscompares++; $display("FAIL reset_swap_pending: got %b expected 0", swap_pending); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL reset_swap_done: got %b expected 0", swap_done); end
  endtask

  task automatic test_write_swap();
    wr_valid = 1'b1; wr_chain = 2'd1; wr_half = 1'b0; wr_y = 4'd3; wr_x = 7'd5;
    wr_rgb = {12'hFFF, 12'h000, 12'hAAA};
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL ws_wr_ready: got %b expected 1", wr_ready); end
    tick(1);
    wr_valid = 1'b0; swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    vectors++; if (swap_pending !== 1'b1) begin miscompares++; $display("FAIL ws_pending: got %b expected 1", swap_pending); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ws_ready_blocked: got %b expected 0", wr_ready); end
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL ws_front_before: got %b expected 0", front_sel); end
    ctl_vsync = 1'b1;
    tick(1);
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL ws_done_pulse: got %b expected 1", swap_done); end
    vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL ws_front_after: got %b expected 1", front_sel); end
    vectors++; if (swap_pending !== 1'b0) begin miscompares++; $display("FAIL ws_pending_clear: got %b expected 0", swap_pending); end
    ctl_vsync = 1'b0;
    tick(1);
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL ws_done_one_cycle: got %b expected 0", swap_done); end
    disp_en = 1'b1; ctl_cur_x = 7'd5; ctl_cur_y = 4'd3; ctl_cur_bit = 4'd1;
    tick(3);
    vectors++; if (led_data[8:6] !== 3'b101) begin miscompares++; $display("FAIL ws_read_bit1: got %b expected 101", led_data[8:6]); end
    ctl_cur_bit = 4'd0;
    tick(2);
    vectors++; if (led_data[8:6] !== 3'b101) begin miscompares++; $display("FAIL ws_latency_hold: got %b expected 101", led_data[8:6]); end
    tick(1);
    vectors++; if (led_data[8:6] !== 3'b001) begin miscompares++; $display("FAIL ws_read_bit0: got %b expected 001", led_data[8:6]); end
  endtask

  task automatic test_isolation();
    wr_valid = 1'b1; wr_chain = 2'd1; wr_half = 1'b0; wr_y = 4'd3; wr_x = 7'd5;
    wr_rgb = {12'h000, 12'hFFF, 12'h000};
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL iso_wr_ready: got %b expected 1", wr_ready); end
    tick(1);
    wr_valid = 1'b0;
    tick(4);
    vectors++; if (led_data[8:6] !== 3'b001) begin miscompares++; $display("FAIL iso_front_unchanged: got %b expected 001", led_data[8:6]); end
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0; ctl_vsync = 1'b1;
    tick(1);
    ctl_vsync = 1'b0;
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL iso_front_sel: got %b expected 0", front_sel); end
    tick(3);
    vectors++; if (led_data[8:6] !== 3'b010) begin miscompares++; $display("FAIL iso_new_pixel: got %b expected 010", led_data[8:6]); end
  endtask

  task automatic test_pending_block();
    swap_req = 1'b1; wr_valid = 1'b1; wr_chain = 2'd0; wr_half = 1'b1; wr_y = 4'd7; wr_x = 7'd9;
    wr_rgb = '1;
    tick(1);
    swap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL pb_ready_low[%0d]: got %b expected 0", i, wr_ready); end
      tick(1);
    end
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    vectors++; if (swap_pending !== 1'b1) begin miscompares++; $display("FAIL pb_still_pending: got %b expected 1", swap_pending); end
    ctl_vsync = 1'b1;
    tick(1);
    vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL pb_front: got %b expected 1", front_sel); end
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL pb_done: got %b expected 1", swap_done); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL pb_ready_back: got %b expected 1", wr_ready); end
    wr_valid = 1'b0; ctl_vsync = 1'b0;
    tick(1);
    ctl_vsync = 1'b1;
    tick(1);
    vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL pb_no_second_swap: got %b expected 1", front_sel); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL pb_no_second_done: got %b expected 0", swap_done); end
    vectors++; if (swap_pending !== 1'b0) begin miscompares++; $display("FAIL pb_idle: got %b expected 0", swap_pending); end
    ctl_vsync = 1'b0;
    tick(1);
  endtask

  task automatic test_simultaneous();
    swap_req = 1'b1; ctl_vsync = 1'b1;
    tick(1);
    swap_req = 1'b0;
    vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL sim_no_swap: got %b expected 1", front_sel); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL sim_no_done: got %b expected 0", swap_done); end
    vectors++; if (swap_pending !== 1'b1) begin miscompares++; $display("FAIL sim_pending: got %b expected 1", swap_pending); end
    ctl_vsync = 1'b0;
    tick(1);
    vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL sim_wait: got %b expected 1", front_sel); end
    ctl_vsync = 1'b1;
    tick(1);
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL sim_swap_next: got %b expected 0", front_sel); end
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL sim_done_next: got %b expected 1", swap_done); end
    ctl_vsync = 1'b0;
    tick(1);
  endtask

  task automatic test_gating();
    disp_en = 1'b1; ctl_cur_x = 7'd5; ctl_cur_y = 4'd3; ctl_cur_bit = 4'd11;
    tick(3);
    vectors++; if (led_data[8:6] !== 3'b010) begin miscompares++; $display("FAIL gate_bit11: got %b expected 010", led_data[8:6]); end
    disp_en = 1'b0;
    tick(3);
    vectors++; if (led_data !== 24'h0) begin miscompares++; $display("FAIL gate_disp_off: got %h expected 000000", led_data); end
    disp_en = 1'b1; ctl_cur_bit = 4'd12;
    tick(3);
    vectors++; if (led_data !== 24'h0) begin miscompares++; $display("FAIL gate_bit12: got %h expected 000000", led_data); end
    ctl_cur_bit = 4'd11;
    tick(3);
    vectors++; if (led_data[8:6] !== 3'b010) begin miscompares++; $display("FAIL gate_recover: got %b expected 010", led_data[8:6]); end
  endtask

  task automatic test_reset_midop();
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0; ctl_vsync = 1'b1;
    tick(1);
    ctl_vsync = 1'b0;
    tick(3);
    vectors++; if (led_data[8:6] !== 3'b101) begin miscompares++; $display("FAIL rm_buf1_bit11: got %b expected 101", led_data[8:6]); end
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    vectors++; if (swap_pending !== 1'b1) begin miscompares++; $display("FAIL rm_pending: got %b expected 1", swap_pending); end
    #2 sys_rst = 1'b0;
    #1;
    vectors++; if (led_data !== 24'h0) begin miscompares++; $display("FAIL rm_led_async: got %h expected 000000", led_data); end
    vectors++; if (swap_pending !== 1'b0) begin miscompares++; $display("FAIL rm_pending_lost: got %b expected 0", swap_pending); end
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL rm_front: got %b expected 0", front_sel); end
    tick(1);
    sys_rst = 1'b1;
    tick(1);
    ctl_vsync = 1'b1;
    tick(1);
    vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL rm_no_swap_after: got %b expected 0", front_sel); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL rm_no_done_after: got %b expected 0", swap_done); end
    ctl_vsync = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_isolation();
    test_pending_block();
    test_simultaneous();
    test_gating();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
